// File: rtl/dbus_arbiter.sv
// Purpose: round-robin two-master / one-slave data bus arbiter with in-order response routing.
// Latency: zero-cycle grant and response paths; grant, lock, count and owner state update on the clock edge.
// Backpressure: slave stall locks the selected master's address phase; issue stops while MAX_OUT responses are in flight.
module dbus_arbiter #(
    parameter int MAX_OUT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_be,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,
    input  logic            m1_req,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_be,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,
    output logic            s_req,
    output logic [AW-1:0]   s_addr,
    output logic            s_we,
    output logic [DW/8-1:0] s_be,
    output logic [DW-1:0]   s_wdata,
    input  logic            s_gnt,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_err,
    output logic            proto_err
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [MAX_OUT-1:0] owner_q, owner_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               lock_q, lock_d;
    logic               locked_id_q, locked_id_d;
    logic               last_q, last_d;
    logic               proto_err_q, proto_err_d;

    logic sel;
    logic m_sel_req;
    logic can_issue;
    logic hs;
    logic pop;
    logic head;

    // Owner FIFO pointers wrap modulo MAX_OUT, which need not fill the pointer width.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pick the master: a locked address phase wins, otherwise round robin on a tie.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = locked_id_q;
        end else if (m0_req && m1_req) begin
            sel = ~last_q;
        end else if (m1_req) begin
            sel = 1'b1;
        end
    end

    // Request/grant and response routing; the issue gate looks only at registered count.
    always_comb begin
        m_sel_req = sel ? m1_req : m0_req;
        can_issue = (cnt_q < MAX_CNT);
        s_req     = can_issue & m_sel_req & ~reset;
        s_addr    = sel ? m1_addr  : m0_addr;
        s_we      = sel ? m1_we    : m0_we;
        s_be      = sel ? m1_be    : m0_be;
        s_wdata   = sel ? m1_wdata : m0_wdata;
        hs        = s_req & s_gnt;
        m0_gnt    = hs & ~sel;
        m1_gnt    = hs & sel;
        pop       = s_rvalid & (cnt_q != '0) & ~reset;
        head      = owner_q[rd_ptr_q];
        m0_rvalid = pop & ~head;
        m1_rvalid = pop & head;
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
        m0_err    = s_err;
        m1_err    = s_err;
        proto_err = proto_err_q & ~reset;
    end

    // Next state: owner push/pop, outstanding count, lock tracking, sticky protocol error.
    always_comb begin
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        last_d      = last_q;
        proto_err_d = proto_err_q;
        if (hs) begin
            owner_d[wr_ptr_q] = sel;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
            last_d            = sel;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (hs) begin
            lock_d = 1'b0;
        end else if (s_req) begin
            // Stalled by the slave: hold this master until it is granted.
            lock_d      = 1'b1;
            locked_id_d = sel;
        end else if (lock_q && !m_sel_req) begin
            // Locked master withdrew its request; release without granting.
            lock_d = 1'b0;
        end
        if (s_rvalid && (cnt_q == '0)) begin
            proto_err_d = 1'b1;
        end
    end

    // State registers with synchronous reset; master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            owner_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
            last_q      <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Purpose: directed bench for dbus_arbiter (vector table plus multi-cycle sequences).
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled 3 units later.
// Backpressure: slave grant and response are driven directly per cycle by the bench.
module tb_dbus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_we, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err, proto_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int n_tests = 0;
    int n_fail  = 0;

    dbus_arbiter #(.MAX_OUT(2), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, r0, r1, gnt, rv, err;
        logic [31:0] rdata;
        logic        e_sreq, e_sel, e_g0, e_g1, e_rv0, e_rv1, e_perr;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input logic rst, r0, r1, gnt, rv, err, input logic [31:0] rdata,
                                input logic e_sreq, e_sel, e_g0, e_g1, e_rv0, e_rv1, e_perr);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.rv = rv; v.err = err; v.rdata = rdata;
        v.e_sreq = e_sreq; v.e_sel = e_sel; v.e_g0 = e_g0; v.e_g1 = e_g1;
        v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_perr = e_perr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, r0, r1, gnt, rv, err, input logic [31:0] rdata);
        reset = rst; m0_req = r0; m1_req = r1; s_gnt = gnt;
        s_rvalid = rv; s_err = err; s_rdata = rdata;
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks the arbiter view of one cycle; the address-phase fields follow the expected selection.
    task automatic hchk(input string nm, input logic e_sreq, e_sel, e_g0, e_g1, e_rv0, e_rv1);
        chk({nm, " s_req"}, 32'(s_req), 32'(e_sreq));
        chk({nm, " s_addr"}, s_addr, e_sel ? 32'h0000_0020 : 32'h0000_0004);
        chk({nm, " s_we"}, 32'(s_we), e_sel ? 32'd1 : 32'd0);
        chk({nm, " s_be"}, 32'(s_be), e_sel ? 32'h4 : 32'hF);
        chk({nm, " s_wdata"}, s_wdata, e_sel ? 32'h00AB_0000 : 32'h1234_5678);
        chk({nm, " gnt"}, {30'd0, m1_gnt, m0_gnt}, {30'd0, e_g1, e_g0});
        chk({nm, " rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, {30'd0, e_rv1, e_rv0});
    endtask

    initial begin
        logic        rv;
        logic        exp_req;
        int          q[$];
        int          grants;

        m0_addr = 32'h0000_0004; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h1234_5678;
        m1_addr = 32'h0000_0020; m1_we = 1'b1; m1_be = 4'b0100; m1_wdata = 32'h00AB_0000;

        //            rst r0 r1 gnt rv err rdata           sreq sel g0 g1 rv0 rv1 perr
        vt[0]  = mk(0, 1, 0, 1, 0, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF,  0, 0, 0, 0, 1, 0, 0);
        vt[2]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vt[3]  = mk(0, 1, 1, 1, 0, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
        vt[4]  = mk(0, 1, 1, 1, 1, 0, 32'h1111_1111,  1, 1, 0, 1, 1, 0, 0);
        vt[5]  = mk(0, 1, 1, 1, 1, 0, 32'h2222_2222,  1, 0, 1, 0, 0, 1, 0);
        vt[6]  = mk(0, 1, 1, 1, 1, 0, 32'h3333_3333,  1, 1, 0, 1, 1, 0, 0);
        vt[7]  = mk(0, 0, 0, 0, 1, 0, 32'h4444_4444,  0, 0, 0, 0, 0, 1, 0);
        vt[8]  = mk(0, 0, 1, 1, 0, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
        vt[9]  = mk(0, 0, 0, 0, 1, 1, 32'hCAFE_F00D,  0, 0, 0, 0, 0, 1, 0);
        vt[10] = mk(0, 0, 0, 0, 1, 0, 32'h5555_5555,  0, 0, 0, 0, 0, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1);
        vt[13] = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);

        // Reset, then check the idle reset state.
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        hchk("reset", 0, 0, 0, 0, 0, 0);
        chk("reset proto_err", 32'(proto_err), 32'd0);
        next_cycle();

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].rst, vt[i].r0, vt[i].r1, vt[i].gnt, vt[i].rv, vt[i].err, vt[i].rdata);
            hchk($sformatf("row%0d", i), vt[i].e_sreq, vt[i].e_sel, vt[i].e_g0, vt[i].e_g1,
                 vt[i].e_rv0, vt[i].e_rv1);
            chk($sformatf("row%0d m0_rdata", i), m0_rdata, vt[i].rdata);
            chk($sformatf("row%0d m1_rdata", i), m1_rdata, vt[i].rdata);
            chk($sformatf("row%0d err", i), {30'd0, m1_err, m0_err}, {30'd0, vt[i].err, vt[i].err});
            chk($sformatf("row%0d proto_err", i), 32'(proto_err), 32'(vt[i].e_perr));
            next_cycle();
        end

        // Address-phase lock: m1 stalls alone, then m0 joins while last favours m0.
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        drive(0, 0, 1, 0, 0, 0, 32'h0); hchk("lock a", 1, 1, 0, 0, 0, 0); next_cycle();
        drive(0, 1, 1, 0, 0, 0, 32'h0); hchk("lock b", 1, 1, 0, 0, 0, 0); next_cycle();
        drive(0, 1, 1, 0, 0, 0, 32'h0); hchk("lock c", 1, 1, 0, 0, 0, 0); next_cycle();
        drive(0, 1, 1, 1, 0, 0, 32'h0); hchk("lock d", 1, 1, 0, 1, 0, 0); next_cycle();
        drive(0, 1, 1, 1, 0, 0, 32'h0); hchk("lock e", 1, 0, 1, 0, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h0); hchk("lock f", 0, 0, 0, 0, 0, 1); next_cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h0); hchk("lock g", 0, 0, 0, 0, 1, 0); next_cycle();
        // Locked master drops its request: no grant that cycle, lock released after.
        drive(0, 1, 0, 0, 0, 0, 32'h0); hchk("drop h", 1, 0, 0, 0, 0, 0); next_cycle();
        drive(0, 0, 1, 1, 0, 0, 32'h0); hchk("drop i", 0, 0, 0, 0, 0, 0); next_cycle();
        drive(0, 0, 1, 1, 0, 0, 32'h0); hchk("drop j", 1, 1, 0, 1, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h0); hchk("drop k", 0, 0, 0, 0, 0, 1); next_cycle();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        chk("lock proto_err", 32'(proto_err), 32'd0);
        next_cycle();

        // Outstanding limit: slave always grants, responds 4 cycles after each grant.
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        next_cycle();
        grants = 0;
        for (int t = 0; t < 18; t++) begin
            rv = (q.size() > 0) && ((t - q[0]) >= 4);
            exp_req = (t < 12) && (q.size() < 2);
            drive(0, (t < 12), 0, 1, rv, 0, 32'(t));
            chk($sformatf("out t%0d s_req", t), 32'(s_req), 32'(exp_req));
            chk($sformatf("out t%0d m0_gnt", t), 32'(m0_gnt), 32'(exp_req));
            chk($sformatf("out t%0d m0_rvalid", t), 32'(m0_rvalid), 32'(rv));
            grants += int'(m0_gnt);
            if (rv) void'(q.pop_front());
            if (exp_req) q.push_back(t);
            next_cycle();
        end
        chk("out total grants", 32'(grants), 32'd6);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        chk("out proto_err", 32'(proto_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master, one-slave arbiter for the core data bus, using the req/gnt/rvalid/err protocol.
- Master 0 is the core LSU. Master 1 is a DMA or host-side engine that shares the simulated SD/file peripheral and data memory.
- Round-robin arbitration. Address-phase lock while the slave stalls. Up to MAX_OUT responses in flight, routed back through an owner FIFO.

Parameters:
MAX_OUT, 2, maximum outstanding (granted, not yet rvalid) transactions; power of two, 1..4
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
mN_req  in  1  master N request, N in {0,1} (one port per master)
mN_addr  in  AW  master N address
mN_we  in  1  master N write enable
mN_be  in  DW/8  master N byte enables
mN_wdata  in  DW  master N write data
mN_gnt  out  1  master N address phase accepted
mN_rvalid  out  1  master N response valid
mN_rdata  out  DW  master N read data
mN_err  out  1  master N response error
s_req  out  1  slave request
s_addr  out  AW  slave address
s_we  out  1  slave write enable
s_be  out  DW/8  slave byte enables
s_wdata  out  DW  slave write data
s_gnt  in  1  slave grant
s_rvalid  in  1  slave response valid
s_rdata  in  DW  slave read data
s_err  in  1  slave response error
proto_err  out  1  sticky: s_rvalid seen with no outstanding transaction

Behaviour:
- Reset, synchronous, active-high:
  - cnt=0, owner FIFO empty, lock=0, last=1 (master 0 wins the first tie), proto_err=0.
  - All outputs that depend on registers are 0 during and after reset.
- can_issue = (cnt < MAX_OUT).
- Selection, combinational:
  - If lock=1, sel = locked_id.
  - Else if only one mN_req is high, sel = that master.
  - If both are high, sel = !last (round robin).
- s_req = can_issue & m_sel_req. s_addr, s_we, s_be and s_wdata are muxed from sel. When s_req=0 they still show the sel master's fields.
- m_sel_gnt = s_req & s_gnt. The other master's gnt = 0. Zero latency: gnt is in the same cycle as the slave gnt.
- Lock:
  - If s_req=1 and s_gnt=0, set lock=1 and locked_id=sel at the clock edge. The address phase must stay stable until granted.
  - Clear lock on a handshake (s_req & s_gnt).
  - If a master drops req while locked (protocol violation), clear lock the next cycle. No grant is issued.
- On a handshake:
  - Push sel into the owner FIFO.
  - cnt+1.
  - last <= sel.
- Response routing:
  - On s_rvalid with cnt>0, pop the FIFO head h. m{h}_rvalid=s_rvalid in the same cycle; the other master's rvalid=0.
  - rdata and err are broadcast to both masters unconditionally.
  - cnt-1.
- Push and pop in the same cycle: cnt unchanged; FIFO pointers both advance.
- A grant is blocked while cnt==MAX_OUT, even if s_rvalid arrives that cycle. No rvalid-to-req combinational path.
- s_rvalid with cnt==0:
  - Dropped; no mN_rvalid is asserted.
  - proto_err <= 1, held until reset.
- Pointer wrap is modulo MAX_OUT. Responses are strictly in order.
- Reset mid-operation: in-flight responses are forgotten. Late rvalids set proto_err, so the bench must drain the slave before asserting reset.

Test Plan:
- Only m0 requests, read 0x0000_0004, slave gnt immediate, rvalid 1 cycle later with 0xDEADBEEF -> m0_gnt in the same cycle, m0_rvalid=1 with rdata 0xDEADBEEF; m1_gnt and m1_rvalid stay 0.
- Both masters request continuously, slave always grants, rvalid 1 cycle later -> grants alternate m0, m1, m0, m1 after reset; each rvalid routed to the matching owner.
- Both request, slave holds s_gnt=0 for 3 cycles, m1 currently selected -> s_addr stays equal to m1_addr for all 3 cycles; on the 4th cycle s_gnt=1 gives m1_gnt; m0 is granted next.
- MAX_OUT=2, slave grants every cycle but delays rvalid 4 cycles -> exactly 2 grants, then s_req=0 until the first rvalid; then one new grant per retired response; cnt never exceeds 2.
- m1 write 0x20 with be=0100, wdata=0x00AB0000, error response s_err=1 -> s_we=1, s_be=0100; m1_rvalid=1 and m1_err=1; m0_rvalid=0.
- Idle bus, inject s_rvalid=1 -> no mN_rvalid; proto_err=1 next cycle and stays high until reset=1 for one cycle, then 0.
